// File: rtl/i2c_line_filter.sv
// Receive-side SCL/SDA conditioner: 2-flop synchronisers, glitch filters and START/STOP/edge strobes.
// Optional bus_busy tracking is compiled in when I2C_LINE_FILTER_BUSY_EN is defined.
module i2c_line_filter #(
  parameter int FILTER_LEN = 4,
  parameter int CNT_W      = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic bus_busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
  localparam int SCL_I = 1;
  localparam int SDA_I = 0;

  // Both lines are processed side by side: bit 1 is SCL, bit 0 is SDA.
  logic [1:0]       s1;
  logic [1:0]       s2;
  logic [1:0]       filt;
  logic [1:0]       filt_next;
  logic [CNT_W-1:0] cnt      [2];
  logic [CNT_W-1:0] cnt_next [2];

  logic rise_next;
  logic fall_next;
  logic start_next;
  logic stop_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 2'b11;
      s2 <= 2'b11;
    end else begin
      s1 <= {scl_in, sda_in};
      s2 <= s1;
    end
  end

  // A differing level must persist for FILTER_LEN evaluations; any return clears the count.
  always_comb begin
    filt_next = filt;
    for (int i = 0; i < 2; i++) begin
      cnt_next[i] = '0;
      if (s2[i] != filt[i]) begin
        if (cnt[i] == CNT_LAST) begin
          filt_next[i] = s2[i];
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // START/STOP need SCL high both before and after the edge, so a simultaneous SCL change blocks them.
  always_comb begin
    rise_next  = filt_next[SCL_I] & ~filt[SCL_I];
    fall_next  = ~filt_next[SCL_I] & filt[SCL_I];
    start_next = filt[SCL_I] & filt_next[SCL_I] & filt[SDA_I] & ~filt_next[SDA_I];
    stop_next  = filt[SCL_I] & filt_next[SCL_I] & ~filt[SDA_I] & filt_next[SDA_I];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt     <= 2'b11;
      cnt[0]   <= '0;
      cnt[1]   <= '0;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      start    <= 1'b0;
      stop     <= 1'b0;
    end else begin
      filt     <= filt_next;
      cnt[0]   <= cnt_next[0];
      cnt[1]   <= cnt_next[1];
      scl_rise <= rise_next;
      scl_fall <= fall_next;
      start    <= start_next;
      stop     <= stop_next;
    end
  end

  assign scl = filt[SCL_I];
  assign sda = filt[SDA_I];

`ifdef I2C_LINE_FILTER_BUSY_EN
  logic busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
    end else if (start_next) begin
      busy_q <= 1'b1;
    end else if (stop_next) begin
      busy_q <= 1'b0;
    end
  end

  assign bus_busy = busy_q;
`else
  assign bus_busy = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_line_filter.sv
// Self-checking bench for i2c_line_filter: directed scenarios plus randomized pin activity
// compared against a run-length reference model of the synchronise-and-filter behaviour.
module tb_i2c_line_filter;

  localparam int FILTER_LEN = 4;
  localparam int CNT_W      = 3;
  localparam int HIST_LEN   = FILTER_LEN + 2;
`ifdef I2C_LINE_FILTER_BUSY_EN
  localparam logic BUSY_ON = 1'b1;
`else
  localparam logic BUSY_ON = 1'b0;
`endif

  // clock / reset
  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic scl_in = 1'b1;
  logic sda_in = 1'b1;
  logic scl, sda, scl_rise, scl_fall, start, stop, bus_busy;

  always #5 clk = ~clk;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .scl      (scl),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop),
    .bus_busy (bus_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: pin sample history per line, oldest first
  bit scl_hist[$];
  bit sda_hist[$];
  bit m_scl, m_sda, m_busy, m_rise, m_fall, m_start, m_stop;

  // Filtered level flips when the last FILTER_LEN synchronised samples (2 edges old) all differ from it.
  function automatic bit qualified(input bit h[$], input bit f);
    for (int i = 0; i < FILTER_LEN; i++) begin
      if (h[i] == f) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    scl_hist.delete();
    sda_hist.delete();
    for (int i = 0; i < HIST_LEN; i++) begin
      scl_hist.push_back(1'b1);
      sda_hist.push_back(1'b1);
    end
    m_scl = 1'b1; m_sda = 1'b1; m_busy = 1'b0;
    m_rise = 1'b0; m_fall = 1'b0; m_start = 1'b0; m_stop = 1'b0;
  endtask

  task automatic model_edge(input bit c, input bit d);
    bit n_scl, n_sda;
    scl_hist.push_back(c); void'(scl_hist.pop_front());
    sda_hist.push_back(d); void'(sda_hist.pop_front());
    n_scl   = qualified(scl_hist, m_scl) ? ~m_scl : m_scl;
    n_sda   = qualified(sda_hist, m_sda) ? ~m_sda : m_sda;
    m_rise  = !m_scl && n_scl;
    m_fall  = m_scl && !n_scl;
    m_start = m_scl && n_scl && m_sda && !n_sda;
    m_stop  = m_scl && n_scl && !m_sda && n_sda;
    if (BUSY_ON && m_start) m_busy = 1'b1;
    else if (m_stop) m_busy = 1'b0;
    m_scl = n_scl;
    m_sda = n_sda;
  endtask

  // observed activity, used by the directed checks
  int cyc = 0;
  int n_start = 0, n_stop = 0, n_rise = 0, n_fall = 0;
  int last_rise_cyc = 0, last_fall_cyc = 0;

  // driver: pins (and reset) change at negedge, outputs sampled 1 time unit after posedge
  task automatic cycle(input bit c, input bit d, input bit r = 1'b0);
    @(negedge clk);
    scl_in = c;
    sda_in = d;
    reset  = r;
    @(posedge clk);
    if (r) model_reset();
    else   model_edge(c, d);
    #1;
    cyc++;
    check("outputs", {25'd0, scl, sda, scl_rise, scl_fall, start, stop, bus_busy},
          {25'd0, m_scl, m_sda, m_rise, m_fall, m_start, m_stop, m_busy});
    if (start)    n_start++;
    if (stop)     n_stop++;
    if (scl_rise) begin n_rise++; last_rise_cyc = cyc; end
    if (scl_fall) begin n_fall++; last_fall_cyc = cyc; end
  endtask

  task automatic hold(input bit c, input bit d, input int n);
    for (int i = 0; i < n; i++) cycle(c, d);
  endtask

  // Drives fixed pins until the selected strobe is seen; returns cycles taken (31 if never).
  task automatic run_until(input bit c, input bit d, input int sel, output int n);
    logic hit;
    n = 31;
    for (int i = 1; i <= 30; i++) begin
      cycle(c, d);
      case (sel)
        0:       hit = start;
        1:       hit = stop;
        2:       hit = scl_fall;
        default: hit = scl_rise;
      endcase
      if (hit) begin
        n = i;
        break;
      end
    end
  endtask

  int n;
  int f0, s0, p0, r0;

  initial begin
    model_reset();
    // reset with pins high, then idle
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1);
    check("reset_levels", {30'd0, scl, sda}, 32'd3);
    hold(1'b1, 1'b1, 20);
    check("idle_strobes", n_start + n_stop + n_rise + n_fall, 0);
    check("idle_levels", {30'd0, scl, sda}, 32'd3);

    // START then SCL low, both with the 6-edge latency
    run_until(1'b1, 1'b0, 0, n);
    check("start_latency", n, 6);
    check("start_sda", sda, 1'b0);
    check("busy_after_start", bus_busy, BUSY_ON);
    run_until(1'b0, 1'b0, 2, n);
    check("fall_latency", n, 6);

    // glitch rejection on SCL while high
    run_until(1'b1, 1'b0, 3, n);
    check("rise_latency", n, 6);
    hold(1'b1, 1'b0, 10);
    f0 = n_fall; r0 = n_rise;
    hold(1'b0, 1'b0, 3);
    hold(1'b1, 1'b0, 12);
    check("glitch3_falls", n_fall - f0, 0);
    check("glitch3_rises", n_rise - r0, 0);
    check("glitch3_scl", scl, 1'b1);
    hold(1'b0, 1'b0, 4);
    hold(1'b1, 1'b0, 12);
    check("pulse4_falls", n_fall - f0, 1);
    check("pulse4_width", last_rise_cyc - last_fall_cyc, 4);

    // STOP, START, repeated START, STOP
    run_until(1'b1, 1'b1, 1, n);
    check("stop_latency", n, 6);
    check("busy_after_stop", bus_busy, 1'b0);
    hold(1'b1, 1'b1, 4);
    run_until(1'b1, 1'b0, 0, n);
    check("start2_seen", n, 6);
    hold(1'b0, 1'b0, 10);
    hold(1'b0, 1'b1, 10);
    hold(1'b1, 1'b1, 10);
    s0 = n_start;
    hold(1'b1, 1'b0, 10);
    check("rep_start_count", n_start - s0, 1);
    check("busy_rep_start", bus_busy, BUSY_ON);
    hold(1'b1, 1'b1, 10);
    check("busy_final_stop", bus_busy, 1'b0);

    // simultaneous SCL/SDA fall: edge strobe only
    f0 = n_fall; s0 = n_start; p0 = n_stop;
    hold(1'b0, 1'b0, 10);
    check("simul_fall", n_fall - f0, 1);
    check("simul_start", n_start - s0, 0);
    check("simul_stop", n_stop - p0, 0);

    // reset two cycles into SCL fall qualification
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b1, 2);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    check("midreset_scl", scl, 1'b1);
    run_until(1'b0, 1'b1, 2, n);
    check("midreset_latency", n, 6);

    // randomized pin activity with short and long runs
    hold(1'b1, 1'b1, 10);
    for (int k = 0; k < 400; k++) begin
      bit c, d;
      int len;
      c   = 1'($urandom_range(0, 1));
      d   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      hold(c, d, len);
    end
    hold(1'b1, 1'b1, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
